// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared encodings for the writeback stage: result-source select values,
// load-type codes and the writeback FSM state type.
// -----------------------------------------------------------------------------
package wb_pkg;

  // Result source select (in_wb_sel). 2'b11 also selects the ALU result.
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  // Load type (in_load_type). 3'b111 is treated as a full-width load.
  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LD  = 3'b011;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;
  localparam logic [2:0] LOAD_LWU = 3'b110;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_stage_pipe_load_extract.sv
// -----------------------------------------------------------------------------
// load_extract
// Combinational lane selection and sign/zero extension of a memory read word.
//
// Ports:
//   data_i      [DATA_W-1:0]  raw memory read data
//   load_type_i [2:0]         load type code (wb_pkg LOAD_*)
//   byte_off_i  [OFF_W-1:0]   low address bits of the load
//   data_o      [DATA_W-1:0]  extracted, extended value
// -----------------------------------------------------------------------------
module load_extract
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [2:0]        load_type_i,
  input  logic [OFF_W-1:0]  byte_off_i,
  output logic [DATA_W-1:0] data_o
);

  logic [OFF_W-1:0]  lane_off;
  logic [DATA_W-1:0] lane_data;

  always_comb begin
    // Round the offset down to the access size; full-width loads use lane 0.
    // With DATA_W=32 the word mask clears every offset bit, so LW/LWU return
    // the whole word.
    lane_off = '0;
    case (load_type_i)
      LOAD_LB, LOAD_LBU: lane_off = byte_off_i;
      LOAD_LH, LOAD_LHU: lane_off = byte_off_i & ~OFF_W'(1);
      LOAD_LW, LOAD_LWU: lane_off = byte_off_i & ~OFF_W'(3);
      default:           lane_off = '0;
    endcase
  end

  assign lane_data = data_i >> {lane_off, 3'b000};

  always_comb begin
    data_o = data_i;
    // Size casts of signed operands sign-extend; of unsigned ones zero-fill.
    case (load_type_i)
      LOAD_LB:  data_o = DATA_W'($signed(lane_data[7:0]));
      LOAD_LH:  data_o = DATA_W'($signed(lane_data[15:0]));
      LOAD_LW:  data_o = DATA_W'($signed(lane_data[31:0]));
      LOAD_LBU: data_o = DATA_W'(lane_data[7:0]);
      LOAD_LHU: data_o = DATA_W'(lane_data[15:0]);
      LOAD_LWU: data_o = DATA_W'(lane_data[31:0]);
      LOAD_LD:  data_o = data_i;
      default:  data_o = data_i;
    endcase
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// -----------------------------------------------------------------------------
// wb_stage_pipe
// Registered writeback stage: MEM/WB pipeline register, result selection and
// load-data extraction. Emits one single-cycle register-file write per
// committed instruction; write_data/write_reg_out hold between writes.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | ready to accept; non-loads commit on the next cycle
//   WAIT_MEM | load accepted, waiting for mem_rvalid (flush aborts it)
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  MEM-side handshake (in_ready high in IDLE)
//   in_alu_result        ALU result
//   in_pc_plus4          link value
//   in_write_reg         destination register
//   in_reg_write         instruction writes a register
//   in_wb_sel            result source (00 ALU, 01 MEM, 10 PC+4, 11 ALU)
//   in_load_type         load type (wb_pkg LOAD_*)
//   in_byte_off          load address low bits
//   mem_rvalid/mem_rdata memory read response
//   flush                kill pending or incoming instruction
//   write_data           register-file write data
//   write_reg_out        register-file write address
//   reg_write_out        register-file write enable (one-cycle pulse)
//   busy                 a load is waiting for memory
// -----------------------------------------------------------------------------
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int ZERO_REG_EN = 1,
  parameter int OFF_W       = $clog2(DATA_W / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_pc_plus4,
  input  logic [REG_ADDR_W-1:0] in_write_reg,
  input  logic                  in_reg_write,
  input  logic [1:0]            in_wb_sel,
  input  logic [2:0]            in_load_type,
  input  logic [OFF_W-1:0]      in_byte_off,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  flush,
  output logic [DATA_W-1:0]     write_data,
  output logic [REG_ADDR_W-1:0] write_reg_out,
  output logic                  reg_write_out,
  output logic                  busy
);

  wb_state_e state_q, state_d;

  // Holding registers for a load in flight.
  logic [REG_ADDR_W-1:0] write_reg_q;
  logic                  reg_write_q;
  logic [2:0]            load_type_q;
  logic [OFF_W-1:0]      byte_off_q;

  logic [DATA_W-1:0]     write_data_q,    write_data_d;
  logic [REG_ADDR_W-1:0] write_reg_out_q, write_reg_out_d;
  logic                  reg_write_out_q, reg_write_out_d;

  logic                  accept;
  logic                  capture_en;
  logic [DATA_W-1:0]     sel_data;
  logic [DATA_W-1:0]     load_data;

  function automatic logic wr_allowed(input logic [REG_ADDR_W-1:0] rd,
                                      input logic                  we);
    return we && !((ZERO_REG_EN != 0) && (rd == '0));
  endfunction

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == WAIT_MEM);
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    sel_data = in_alu_result;
    case (in_wb_sel)
      WB_SEL_ALU: sel_data = in_alu_result;
      WB_SEL_PC4: sel_data = in_pc_plus4;
      default:    sel_data = in_alu_result;
    endcase
  end

  load_extract #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_extract (
    .data_i      (mem_rdata),
    .load_type_i (load_type_q),
    .byte_off_i  (byte_off_q),
    .data_o      (load_data)
  );

  // Data and address only move when a write actually fires, so they hold
  // their last committed value whenever reg_write_out is low.
  always_comb begin
    state_d         = state_q;
    write_data_d    = write_data_q;
    write_reg_out_d = write_reg_out_q;
    reg_write_out_d = 1'b0;
    capture_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_wb_sel == WB_SEL_MEM) begin
            // Response is only looked at from the next cycle on.
            capture_en = 1'b1;
            state_d    = WAIT_MEM;
          end else if (wr_allowed(in_write_reg, in_reg_write)) begin
            write_data_d    = sel_data;
            write_reg_out_d = in_write_reg;
            reg_write_out_d = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        if (flush) begin
          state_d = IDLE;
        end else if (mem_rvalid) begin
          state_d = IDLE;
          if (wr_allowed(write_reg_q, reg_write_q)) begin
            write_data_d    = load_data;
            write_reg_out_d = write_reg_q;
            reg_write_out_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      write_data_q    <= '0;
      write_reg_out_q <= '0;
      reg_write_out_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      write_data_q    <= write_data_d;
      write_reg_out_q <= write_reg_out_d;
      reg_write_out_q <= reg_write_out_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_reg_q <= '0;
      reg_write_q <= 1'b0;
      load_type_q <= '0;
      byte_off_q  <= '0;
    end else if (capture_en) begin
      write_reg_q <= in_write_reg;
      reg_write_q <= in_reg_write;
      load_type_q <= in_load_type;
      byte_off_q  <= in_byte_off;
    end
  end

  assign write_data    = write_data_q;
  assign write_reg_out = write_reg_out_q;
  assign reg_write_out = reg_write_out_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
module tb_wb_stage_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_reg_write, mem_rvalid, flush;
  logic [63:0] alu, pc4, rdata;
  logic [4:0]  wreg;
  logic [1:0]  sel;
  logic [2:0]  lt, off;

  // Three instances: 0 = 32-bit default, 1 = 64-bit, 2 = 32-bit with
  // register-0 writes allowed.
  logic [31:0] wd_a, wd_c;
  logic [63:0] wd_b;
  logic [4:0]  wr  [3];
  logic        rdy [3];
  logic        bsy [3];
  logic        rwo [3];
  logic [63:0] a_wd[3];

  assign a_wd[0] = {32'h0, wd_a};
  assign a_wd[1] = wd_b;
  assign a_wd[2] = {32'h0, wd_c};

  wb_stage_pipe #(.DATA_W(32), .ZERO_REG_EN(1)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_alu_result(alu[31:0]), .in_pc_plus4(pc4[31:0]), .in_write_reg(wreg),
    .in_reg_write(in_reg_write), .in_wb_sel(sel), .in_load_type(lt),
    .in_byte_off(off[1:0]), .mem_rvalid(mem_rvalid), .mem_rdata(rdata[31:0]),
    .flush(flush), .write_data(wd_a), .write_reg_out(wr[0]),
    .reg_write_out(rwo[0]), .busy(bsy[0]));

  wb_stage_pipe #(.DATA_W(64), .ZERO_REG_EN(1)) u_w64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_alu_result(alu), .in_pc_plus4(pc4), .in_write_reg(wreg),
    .in_reg_write(in_reg_write), .in_wb_sel(sel), .in_load_type(lt),
    .in_byte_off(off), .mem_rvalid(mem_rvalid), .mem_rdata(rdata),
    .flush(flush), .write_data(wd_b), .write_reg_out(wr[1]),
    .reg_write_out(rwo[1]), .busy(bsy[1]));

  wb_stage_pipe #(.DATA_W(32), .ZERO_REG_EN(0)) u_nz (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_alu_result(alu[31:0]), .in_pc_plus4(pc4[31:0]), .in_write_reg(wreg),
    .in_reg_write(in_reg_write), .in_wb_sel(sel), .in_load_type(lt),
    .in_byte_off(off[1:0]), .mem_rvalid(mem_rvalid), .mem_rdata(rdata[31:0]),
    .flush(flush), .write_data(wd_c), .write_reg_out(wr[2]),
    .reg_write_out(rwo[2]), .busy(bsy[2]));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // ---------------- reference model ----------------
  int          dw_k[3] = '{32, 64, 32};
  bit          zr_k[3] = '{1'b1, 1'b1, 1'b0};
  logic [63:0] m_wd  [3];
  logic [4:0]  m_wr  [3];
  logic        m_rwo [3];
  logic        m_pend[3];
  logic [4:0]  p_reg [3];
  logic        p_rw  [3];
  logic [2:0]  p_lt  [3];
  logic [2:0]  p_off [3];

  function automatic logic [63:0] m_extract(int dw, logic [2:0] t, logic [2:0] o,
                                            logic [63:0] rd);
    int sz, lane;
    bit sg;
    logic [63:0] lm, v;
    case (t)
      3'd0: begin sz = 1; sg = 1'b1; end
      3'd1: begin sz = 2; sg = 1'b1; end
      3'd2: begin sz = 4; sg = 1'b1; end
      3'd4: begin sz = 1; sg = 1'b0; end
      3'd5: begin sz = 2; sg = 1'b0; end
      3'd6: begin sz = 4; sg = 1'b0; end
      default: begin sz = dw / 8; sg = 1'b0; end
    endcase
    if (sz >= dw / 8) begin
      sz = dw / 8;
      sg = 1'b0;
    end
    lane = ((int'(o) % (dw / 8)) / sz) * sz;
    v    = rd >> (lane * 8);
    lm   = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (sz * 8)) - 64'd1);
    v    = v & lm;
    if (sg && v[sz*8-1]) v = v | ~lm;
    return (dw == 64) ? v : (v & 64'hFFFF_FFFF);
  endfunction

  function automatic bit m_en(int k, logic [4:0] r, logic w);
    return w && !(zr_k[k] && r == 5'd0);
  endfunction

  task automatic m_step(int k);
    logic [63:0] msk;
    msk = (dw_k[k] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    if (rst) begin
      m_pend[k] = 1'b0; m_wd[k] = '0; m_wr[k] = '0; m_rwo[k] = 1'b0;
      p_reg[k] = '0; p_rw[k] = 1'b0; p_lt[k] = '0; p_off[k] = '0;
      return;
    end
    m_rwo[k] = 1'b0;
    if (!m_pend[k]) begin
      if (in_valid && !flush) begin
        if (sel == 2'b01) begin
          m_pend[k] = 1'b1; p_reg[k] = wreg; p_rw[k] = in_reg_write;
          p_lt[k] = lt; p_off[k] = off;
        end else if (m_en(k, wreg, in_reg_write)) begin
          m_wd[k]  = ((sel == 2'b10) ? pc4 : alu) & msk;
          m_wr[k]  = wreg;
          m_rwo[k] = 1'b1;
        end
      end
    end else if (flush) begin
      m_pend[k] = 1'b0;
    end else if (mem_rvalid) begin
      m_pend[k] = 1'b0;
      if (m_en(k, p_reg[k], p_rw[k])) begin
        m_wd[k]  = m_extract(dw_k[k], p_lt[k], p_off[k], rdata & msk);
        m_wr[k]  = p_reg[k];
        m_rwo[k] = 1'b1;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_pend[k] = 1'b0; m_wd[k] = '0; m_wr[k] = '0; m_rwo[k] = 1'b0;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < 3; k++) m_step(k);
    end
  end

  // ---------------- checking ----------------
  task automatic cmp(string nm, int k, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[inst%0d] t=%0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  task automatic lit(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        cmp("reg_write_out", k, 64'(rwo[k]), 64'(m_rwo[k]));
        cmp("write_data", k, a_wd[k], m_wd[k]);
        cmp("write_reg_out", k, 64'(wr[k]), 64'(m_wr[k]));
        cmp("in_ready", k, 64'(rdy[k]), 64'(!m_pend[k]));
        cmp("busy", k, 64'(bsy[k]), 64'(m_pend[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic issue(logic [1:0] s, logic [63:0] a, logic [63:0] p,
                       logic [4:0] r, logic w);
    in_valid = 1'b1; sel = s; alu = a; pc4 = p; wreg = r; in_reg_write = w;
  endtask

  // Load accepted with a bogus coincident response, real response after
  // wait_n cycles. Returns at the negedge after the committing edge.
  task automatic do_load(logic [2:0] t, logic [2:0] o, logic [4:0] r,
                         logic [63:0] rd, int wait_n);
    issue(2'b01, 64'hDEAD, 64'hBEEF, r, 1'b1);
    lt = t; off = o;
    mem_rvalid = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    in_valid = 1'b0; mem_rvalid = 1'b0;
    lit("load_busy", 64'(bsy[0]), 64'd1);
    lit("load_in_ready", 64'(rdy[0]), 64'd0);
    tick(wait_n - 1);
    mem_rvalid = 1'b1; rdata = rd;
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    sel = '0; alu = '0; pc4 = '0; wreg = '0; in_reg_write = 1'b0;
    lt = '0; off = '0; rdata = '0;
    #1 rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk_en = 1'b1;
    lit("reset_rwo", 64'(rwo[0]), 64'd0);
    lit("reset_wd", 64'(wd_a), 64'd0);
    lit("reset_ready", 64'(rdy[0]), 64'd1);

    // Simple ALU op
    issue(2'b00, 64'h1234, 64'h0, 5'd5, 1'b1);
    tick(); idle();
    lit("alu_rwo", 64'(rwo[0]), 64'd1);
    lit("alu_wr", 64'(wr[0]), 64'd5);
    lit("alu_wd", 64'(wd_a), 64'h1234);
    tick();
    lit("alu_pulse_end", 64'(rwo[0]), 64'd0);
    lit("alu_wd_hold", 64'(wd_a), 64'h1234);

    // Byte loads, response 3 cycles after acceptance
    do_load(3'b000, 3'd2, 5'd7, 64'h1111_1111_0080_0000, 3);
    lit("lb_rwo", 64'(rwo[0]), 64'd1);
    lit("lb_wr", 64'(wr[0]), 64'd7);
    lit("lb_wd32", 64'(wd_a), 64'hFFFF_FF80);
    lit("lb_wd64", wd_b, 64'hFFFF_FFFF_FFFF_FF80);
    lit("lb_model", m_wd[0], 64'hFFFF_FF80);
    tick();
    lit("lb_single_write", 64'(rwo[0]), 64'd0);
    do_load(3'b100, 3'd2, 5'd7, 64'h1111_1111_0080_0000, 3);
    lit("lbu_wd32", 64'(wd_a), 64'h0000_0080);
    lit("lbu_model", m_wd[1], 64'h80);

    // Halfword loads, offset 3 rounds down to 2
    do_load(3'b001, 3'd3, 5'd8, 64'h0000_0000_8001_7FFF, 2);
    lit("lh_wd32", 64'(wd_a), 64'hFFFF_8001);
    lit("lh_wd64", wd_b, 64'hFFFF_FFFF_FFFF_8001);
    do_load(3'b101, 3'd3, 5'd8, 64'h0000_0000_8001_7FFF, 2);
    lit("lhu_wd32", 64'(wd_a), 64'h0000_8001);

    // Word / doubleword loads
    do_load(3'b010, 3'd4, 5'd9, 64'h8000_0000_0000_0000, 1);
    lit("lw_wd64", wd_b, 64'hFFFF_FFFF_8000_0000);
    lit("lw_model", m_wd[1], 64'hFFFF_FFFF_8000_0000);
    do_load(3'b110, 3'd5, 5'd9, 64'h89AB_CDEF_0123_4567, 1);
    lit("lwu_wd64", wd_b, 64'h0000_0000_89AB_CDEF);
    lit("lwu_wd32_full", 64'(wd_a), 64'h0123_4567);
    do_load(3'b011, 3'd3, 5'd9, 64'h0123_4567_89AB_CDEF, 2);
    lit("ld_wd64", wd_b, 64'h0123_4567_89AB_CDEF);
    lit("ld_wd32", 64'(wd_a), 64'h89AB_CDEF);
    do_load(3'b111, 3'd6, 5'd9, 64'hFEDC_BA98_7654_3210, 1);
    lit("ld111_wd64", wd_b, 64'hFEDC_BA98_7654_3210);

    // Flush coincident with response in WAIT_MEM, then an ALU op right away
    issue(2'b01, 64'h0, 64'h0, 5'd10, 1'b1); lt = 3'b010; off = 3'd0;
    tick(); idle();
    tick();
    flush = 1'b1; mem_rvalid = 1'b1; rdata = 64'h5;
    tick();
    flush = 1'b0; mem_rvalid = 1'b0;
    lit("flush_no_write", 64'(rwo[0]), 64'd0);
    lit("flush_ready", 64'(rdy[0]), 64'd1);
    lit("flush_busy", 64'(bsy[0]), 64'd0);
    issue(2'b00, 64'h55, 64'h0, 5'd11, 1'b1);
    tick(); idle();
    lit("post_flush_rwo", 64'(rwo[0]), 64'd1);
    lit("post_flush_wd", 64'(wd_a), 64'h55);

    // Flush in IDLE drops the incoming op
    issue(2'b00, 64'h66, 64'h0, 5'd12, 1'b1); flush = 1'b1;
    tick(); idle();
    lit("idle_flush_rwo", 64'(rwo[0]), 64'd0);
    lit("idle_flush_hold", 64'(wd_a), 64'h55);

    // Stray response in IDLE
    mem_rvalid = 1'b1; rdata = 64'h77;
    tick(); idle();
    lit("stray_rvalid", 64'(rwo[0]), 64'd0);

    // Register 0 via PC+4
    issue(2'b10, 64'h77, 64'h104, 5'd0, 1'b1);
    tick(); idle();
    lit("zero_reg_suppressed", 64'(rwo[0]), 64'd0);
    lit("zero_reg_allowed", 64'(rwo[2]), 64'd1);
    lit("zero_reg_wd", 64'(wd_c), 64'h104);
    lit("zero_reg_wr", 64'(wr[2]), 64'd0);

    // Select 11 picks ALU; reg_write=0 issues nothing
    issue(2'b11, 64'h99, 64'h200, 5'd13, 1'b1);
    tick(); idle();
    lit("sel11_wd", 64'(wd_a), 64'h99);
    issue(2'b00, 64'hAA, 64'h0, 5'd14, 1'b0);
    tick(); idle();
    lit("no_regwrite", 64'(rwo[0]), 64'd0);
    lit("no_regwrite_hold", 64'(wd_a), 64'h99);

    // Four back-to-back ALU ops
    for (int i = 0; i < 4; i++) begin
      issue(2'b00, 64'hA0 + 64'(i), 64'h0, 5'(i + 1), 1'b1);
      tick();
      lit("b2b_rwo", 64'(rwo[0]), 64'd1);
      lit("b2b_wr", 64'(wr[0]), 64'(i + 1));
      lit("b2b_wd", 64'(wd_a), 64'hA0 + 64'(i));
    end
    idle();
    tick();
    lit("b2b_end", 64'(rwo[0]), 64'd0);

    // Asynchronous reset while waiting for memory
    issue(2'b01, 64'h0, 64'h0, 5'd15, 1'b1); lt = 3'b000; off = 3'd0;
    tick(); idle();
    tick();
    lit("pre_rst_busy", 64'(bsy[0]), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    lit("async_rst_wd32", 64'(wd_a), 64'd0);
    lit("async_rst_wd64", wd_b, 64'd0);
    lit("async_rst_wr", 64'(wr[0]), 64'd0);
    lit("async_rst_ready", 64'(rdy[0]), 64'd1);
    lit("async_rst_busy", 64'(bsy[1]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; rdata = 64'h81;
    tick(); idle();
    lit("post_rst_no_write32", 64'(rwo[0]), 64'd0);
    lit("post_rst_no_write64", 64'(rwo[1]), 64'd0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
Registered, parametrised writeback stage. It merges the MEM/WB pipeline register with result selection and load-data extraction.
- Accepts one instruction per cycle from MEM via a valid/ready handshake.
- For loads, waits any number of cycles for the memory response.
- Extracts the byte, halfword, word or doubleword lane from the response, sign- or zero-extended.
- Issues exactly one single-cycle register-file write per committed instruction.
- Sits between the MEM stage/data memory and the register file. Its outputs also feed the forwarding unit.

Parameters:
- DATA_W, 32, datapath width; must be 32 or 64.
- REG_ADDR_W, 5, register-file address width.
- ZERO_REG_EN, 1, when 1, writes to register 0 are suppressed.
- OFF_W, $clog2(DATA_W/8), byte-offset width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  MEM presents an instruction.
- in_ready  out  1  stage can accept; equals (state==IDLE).
- in_alu_result  in  DATA_W  ALU result.
- in_pc_plus4  in  DATA_W  link value.
- in_write_reg  in  REG_ADDR_W  destination register.
- in_reg_write  in  1  instruction writes a register.
- in_wb_sel  in  2  result source: 00 ALU, 01 MEM, 10 PC+4, 11 ALU.
- in_load_type  in  3  load type: 000 LB, 001 LH, 010 LW, 011 LD (full width), 100 LBU, 101 LHU, 110 LWU; 111 treated as LD.
- in_byte_off  in  OFF_W  load address low bits.
- mem_rvalid  in  1  memory read data valid.
- mem_rdata  in  DATA_W  memory read data.
- flush  in  1  kill the pending or incoming instruction.
- write_data  out  DATA_W  register-file write data.
- write_reg_out  out  REG_ADDR_W  register-file write address.
- reg_write_out  out  1  register-file write enable; a single-cycle pulse.
- busy  out  1  a load is waiting (state==WAIT_MEM).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - write_data=0, write_reg_out=0, reg_write_out=0.
  - All captured fields cleared.
- Accept: in_valid && in_ready && !flush at a rising edge. Fields are captured into holding registers.
- IDLE, accepted with in_wb_sel!=01:
  - Next cycle: write_data = selected source, write_reg_out = in_write_reg.
  - reg_write_out = in_reg_write && !(ZERO_REG_EN && in_write_reg==0).
  - Latency is 1 cycle.
- IDLE, accepted with in_wb_sel==01:
  - Go to WAIT_MEM; reg_write_out=0 next cycle.
  - mem_rvalid in the acceptance cycle is ignored. The response is sampled only from the following cycle on.
- WAIT_MEM:
  - mem_rvalid=1 and no flush: write_data = extract(mem_rdata), reg_write_out per the rule above, asserted in the next cycle. Return to IDLE.
  - mem_rvalid=0: hold; in_ready=0.
- Extraction:
  - Lane = byte offset rounded down to the access size. LH/LHU use in_byte_off with bit0 cleared. LW/LWU use it with bits[1:0] cleared. LD ignores the offset.
  - Signed types replicate the lane MSB up to DATA_W. Unsigned types zero-fill.
  - DATA_W=32: LW, LWU and LD all return the full word.
- reg_write_out:
  - High for exactly one cycle per committed instruction; otherwise 0.
  - write_data and write_reg_out hold their last value when reg_write_out=0.
- Flush:
  - Highest priority.
  - In IDLE: the incoming instruction is dropped.
  - In WAIT_MEM: the load is aborted and state returns to IDLE with no write, even if mem_rvalid is coincident.
  - reg_write_out is 0 in the cycle after a flush.
- mem_rvalid in IDLE (stray or late) is ignored.
- Back-to-back: non-load instructions are accepted every cycle at full throughput.
- Reset mid-WAIT_MEM: immediate return to IDLE, no write issued.

Decomposition:
- Package wb_pkg holds:
  - WB_SEL_ALU/MEM/PC4 localparams.
  - LOAD_LB..LOAD_LWU encodings.
  - State encoding IDLE=0, WAIT_MEM=1.
- Sub-module load_extract: purely combinational; inputs data, type, offset; output extended value. Instantiated once.

Test Plan:
- Reset, then ALU op alu=0x0000_1234, reg=5, reg_write=1 -> next cycle reg_write_out=1, write_reg_out=5, write_data=0x1234; following cycle reg_write_out=0.
- LB, off=2, rvalid 3 cycles later with rdata=0x0080_0000 -> in_ready=0 and busy=1 while waiting; one write of 0xFFFF_FF80; LBU with the same stimulus -> 0x0000_0080.
- LH, off=3 (rounded to 2), rdata=0x8001_7FFF -> write_data=0xFFFF_8001; LHU -> 0x0000_8001; DATA_W=64 LW, off=4, rdata=0x8000_0000_0000_0000 -> 0xFFFF_FFFF_8000_0000.
- Load in WAIT_MEM with flush and mem_rvalid in the same cycle -> no write, state IDLE, in_ready=1 next cycle; an immediately following ALU op commits normally.
- reg=0, reg_write=1, PC+4 select, pc4=0x104 -> ZERO_REG_EN=1: reg_write_out stays 0; ZERO_REG_EN=0: single write of 0x104 to reg 0.
- Four back-to-back ALU ops -> four consecutive one-cycle writes in order; rst asserted while in WAIT_MEM -> outputs 0 asynchronously, no write after rst deasserts.
